// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// a hardwired zero register and per-register pending (scoreboard) bits.
// Reads are combinational; writes, reservations and the pending count update
// on the rising edge of clk.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_WR_PORTS = 1,
  parameter int unsigned BYPASS       = 1,
  parameter int unsigned ZERO_REG     = 1,
  localparam int unsigned ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS*ADDR_W-1:0]       wr_reg,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]       rd_reg,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_pending,
  input  logic                                 rsv_en,
  input  logic [ADDR_W-1:0]                    rsv_reg,
  output logic [ADDR_W:0]                      pending_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  // A register is live unless it is the hardwired zero register.
  function automatic logic reg_live(input int unsigned r);
    reg_live = (ZERO_REG == 0) || (r != 0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [CNT_W-1:0]      count_q;

  logic [NUM_REGS-1:0]   wr_hit;
  logic [DATA_WIDTH-1:0] wr_val [NUM_REGS];
  logic [NUM_REGS-1:0]   rsv_set;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic                  cnt_inc;
  logic [CNT_W-1:0]      cnt_dec;
  logic [CNT_W-1:0]      count_nxt;

  assign pending_count = count_q;

  // Per-register write/reserve decode; iterating ports upward lets the
  // highest-indexed port win a same-address collision. Out-of-range
  // addresses never match any register, so they are dropped here.
  always_comb begin
    wr_hit  = '0;
    rsv_set = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_val[r] = '0;
      if (reg_live(r)) begin
        for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_en[p] && (wr_reg[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        rsv_set[r] = rsv_en && (rsv_reg == ADDR_W'(r));
      end
    end
  end

  // Next pending vector and incremental count: a write clears, a reserve
  // sets and wins over a same-cycle write to the same register.
  always_comb begin
    pending_nxt = (pending & ~wr_hit) | rsv_set;
    cnt_inc     = |(rsv_set & ~pending);
    cnt_dec     = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (pending[r] && wr_hit[r] && !rsv_set[r]) begin
        cnt_dec = cnt_dec + CNT_W'(1);
      end
    end
    count_nxt = count_q + CNT_W'(cnt_inc) - cnt_dec;
  end

  // State update; reset discards any write or reserve in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
      pending <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          mem[r] <= wr_val[r];
        end
      end
      pending <= pending_nxt;
      count_q <= count_nxt;
    end
  end

  // Combinational read ports with optional bypass; a bypassed write also
  // masks the pending bit since the value is arriving this cycle.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if ((rd_reg[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) && reg_live(r)) begin
          if ((BYPASS != 0) && wr_hit[r]) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_val[r];
          end else begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[r];
            rd_pending[p]                       = pending[r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: dut_a (2 write ports, bypass, zero reg)
// and dut_b (24 registers, no bypass, no zero reg, 1 read/1 write port).
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a signals
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_reg;
  logic [63:0] a_wr_data;
  logic [9:0]  a_rd_reg;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_pending;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_reg;
  logic [5:0]  a_cnt;

  // dut_b signals
  logic        b_wr_en;
  logic [4:0]  b_wr_reg;
  logic [31:0] b_wr_data;
  logic [4:0]  b_rd_reg;
  logic [31:0] b_rd_data;
  logic        b_rd_pending;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_reg;
  logic [5:0]  b_cnt;

  reg_file_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2),
                .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_reg(a_wr_reg), .wr_data(a_wr_data),
    .rd_reg(a_rd_reg), .rd_data(a_rd_data), .rd_pending(a_rd_pending),
    .rsv_en(a_rsv_en), .rsv_reg(a_rsv_reg), .pending_count(a_cnt));

  reg_file_mp #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_RD_PORTS(1), .NUM_WR_PORTS(1),
                .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_reg(b_wr_reg), .wr_data(b_wr_data),
    .rd_reg(b_rd_reg), .rd_data(b_rd_data), .rd_pending(b_rd_pending),
    .rsv_en(b_rsv_en), .rsv_reg(b_rsv_reg), .pending_count(b_cnt));

  // Scoreboard entry: which output (sel), in which cycle, expected value.
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: observe = a_rd_data[31:0];
      1: observe = a_rd_data[63:32];
      2: observe = {31'b0, a_rd_pending[0]};
      3: observe = {31'b0, a_rd_pending[1]};
      4: observe = {26'b0, a_cnt};
      5: observe = b_rd_data;
      6: observe = {31'b0, b_rd_pending};
      default: observe = {26'b0, b_cnt};
    endcase
  endfunction

  // Monitor: mid-cycle, pop every expectation queued for this cycle.
  sb_t         mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e   = sbq.pop_front();
      mon_act = observe(mon_e.sel);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", mon_e.name, cyc, mon_act, mon_e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
    sb_t e;
    e.cyc = cyc; e.sel = sel; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en = '0; a_wr_reg = '0; a_wr_data = '0; a_rsv_en = 1'b0; a_rsv_reg = '0;
    b_wr_en = 1'b0; b_wr_reg = '0; b_wr_data = '0; b_rsv_en = 1'b0; b_rsv_reg = '0;
  endtask

  task automatic a_wr(input int p, input logic [4:0] r, input logic [31:0] d);
    a_wr_en[p] = 1'b1;
    if (p == 0) begin a_wr_reg[4:0] = r; a_wr_data[31:0] = d; end
    else        begin a_wr_reg[9:5] = r; a_wr_data[63:32] = d; end
  endtask

  task automatic a_rd(input logic [4:0] r0, input logic [4:0] r1);
    a_rd_reg = {r1, r0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    a_rd_reg = '0;
    b_rd_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset sweep of every address on both ports
    for (int r = 0; r < 32; r++) begin
      a_rd(5'(r), 5'(31 - r));
      expect_v("rst_rd0", 0, 32'h0);
      expect_v("rst_rd1", 1, 32'h0);
      expect_v("rst_pend0", 2, 32'h0);
      expect_v("rst_pend1", 3, 32'h0);
      expect_v("rst_cnt", 4, 32'h0);
      tick();
    end

    // Basic write then read on port 1
    idle(); a_wr(0, 5'd5, 32'hDEADBEEF); a_rd(5'd0, 5'd5);
    expect_v("x5_bypass", 1, 32'hDEADBEEF);
    tick();
    idle(); a_rd(5'd0, 5'd5);
    expect_v("x5_read", 1, 32'hDEADBEEF);
    tick();

    // Zero register ignores write and reserve
    idle(); a_wr(0, 5'd0, 32'h1234); a_rsv_en = 1'b1; a_rsv_reg = 5'd0; a_rd(5'd0, 5'd5);
    expect_v("x0_same_rd", 0, 32'h0);
    expect_v("x0_same_pend", 2, 32'h0);
    tick();
    idle(); a_rd(5'd0, 5'd0);
    expect_v("x0_rd", 0, 32'h0);
    expect_v("x0_pend", 2, 32'h0);
    expect_v("x0_cnt", 4, 32'h0);
    tick();

    // Bypass on dut_a, no bypass on dut_b
    idle(); a_wr(0, 5'd7, 32'h11111111);
    b_wr_en = 1'b1; b_wr_reg = 5'd7; b_wr_data = 32'h11111111;
    tick();
    idle(); a_wr(0, 5'd7, 32'hA5A5A5A5); a_rd(5'd7, 5'd0);
    b_wr_en = 1'b1; b_wr_reg = 5'd7; b_wr_data = 32'hA5A5A5A5; b_rd_reg = 5'd7;
    expect_v("a_x7_bypass", 0, 32'hA5A5A5A5);
    expect_v("b_x7_old", 5, 32'h11111111);
    tick();
    idle(); a_rd(5'd7, 5'd0); b_rd_reg = 5'd7;
    expect_v("a_x7_new", 0, 32'hA5A5A5A5);
    expect_v("b_x7_new", 5, 32'hA5A5A5A5);
    tick();

    // Two write ports to the same register: port 1 wins
    idle(); a_wr(0, 5'd3, 32'h11); a_wr(1, 5'd3, 32'h22); a_rd(5'd3, 5'd3);
    expect_v("x3_byp0", 0, 32'h22);
    expect_v("x3_byp1", 1, 32'h22);
    tick();
    idle(); a_rd(5'd0, 5'd3);
    expect_v("x3_read", 1, 32'h22);
    tick();

    // Pending scoreboard
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd4; a_rd(5'd4, 5'd0);
    expect_v("rsv4_same_pend", 2, 32'h0);
    expect_v("rsv4_same_cnt", 4, 32'h0);
    tick();
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd9; a_rd(5'd4, 5'd9);
    expect_v("cnt_1", 4, 32'd1);
    expect_v("pend4", 2, 32'h1);
    expect_v("pend9_early", 3, 32'h0);
    tick();
    idle(); a_rd(5'd4, 5'd9);
    expect_v("cnt_2", 4, 32'd2);
    expect_v("pend9", 3, 32'h1);
    tick();
    idle(); a_wr(0, 5'd4, 32'h44); a_rd(5'd4, 5'd9);
    expect_v("pend4_byp", 2, 32'h0);
    expect_v("x4_byp", 0, 32'h44);
    expect_v("cnt_2_hold", 4, 32'd2);
    tick();
    idle(); a_rd(5'd4, 5'd9);
    expect_v("cnt_after_wr4", 4, 32'd1);
    expect_v("pend4_clr", 2, 32'h0);
    expect_v("x4_read", 0, 32'h44);
    tick();
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd9; a_wr(1, 5'd9, 32'h99); a_rd(5'd4, 5'd9);
    expect_v("x9_byp", 1, 32'h99);
    expect_v("pend9_byp", 3, 32'h0);
    tick();
    idle(); a_rd(5'd4, 5'd9);
    expect_v("x9_read", 1, 32'h99);
    expect_v("pend9_kept", 3, 32'h1);
    expect_v("cnt_rsv_wr", 4, 32'd1);
    tick();
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd9;
    tick();
    idle();
    expect_v("cnt_rersv", 4, 32'd1);
    tick();
    idle(); a_wr(1, 5'd9, 32'h9A);
    tick();
    idle(); a_rd(5'd9, 5'd0);
    expect_v("cnt_0", 4, 32'd0);
    expect_v("x9_final", 0, 32'h9A);
    tick();

    // Reset mid-sequence discards same-cycle write and reserve
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd10;
    tick();
    idle(); rst = 1'b1; a_wr(0, 5'd5, 32'h55); a_rsv_en = 1'b1; a_rsv_reg = 5'd6;
    expect_v("cnt_pre_rst", 4, 32'd1);
    tick();
    rst = 1'b0; idle(); a_rd(5'd5, 5'd6);
    expect_v("rst_x5", 0, 32'h0);
    expect_v("rst_pend6", 3, 32'h0);
    expect_v("rst_cnt2", 4, 32'd0);
    tick();
    idle(); a_rd(5'd3, 5'd10);
    expect_v("rst_x3", 0, 32'h0);
    expect_v("rst_pend10", 3, 32'h0);
    tick();

    // dut_b: out-of-range address and a live register 0
    idle(); b_wr_en = 1'b1; b_wr_reg = 5'd25; b_wr_data = 32'hFFFF; b_rsv_en = 1'b1; b_rsv_reg = 5'd25; b_rd_reg = 5'd25;
    expect_v("b_inv_same", 5, 32'h0);
    tick();
    idle(); b_rd_reg = 5'd25;
    expect_v("b_inv_rd", 5, 32'h0);
    expect_v("b_inv_pend", 6, 32'h0);
    expect_v("b_inv_cnt", 7, 32'h0);
    tick();
    idle(); b_wr_en = 1'b1; b_wr_reg = 5'd0; b_wr_data = 32'h77; b_rsv_en = 1'b1; b_rsv_reg = 5'd0; b_rd_reg = 5'd0;
    expect_v("b_x0_old", 5, 32'h0);
    tick();
    idle(); b_rd_reg = 5'd0;
    expect_v("b_x0_rd", 5, 32'h77);
    expect_v("b_x0_pend", 6, 32'h1);
    expect_v("b_x0_cnt", 7, 32'd1);
    tick();
    idle(); b_rd_reg = 5'd23; b_wr_en = 1'b1; b_wr_reg = 5'd23; b_wr_data = 32'hCAFE;
    tick();
    idle(); b_rd_reg = 5'd23;
    expect_v("b_x23_rd", 5, 32'hCAFE);
    tick();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the RISC-V core, the successor to the fixed 32x32, 2-read/1-write register file. It adds configurable width, depth and port counts, an optional write-to-read bypass, and a per-register pending (scoreboard) bit so pipelined issue logic can detect reads of in-flight destinations. It sits between decode/issue (read and reserve ports) and writeback (write ports).

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (≥2); ADDR_W = $clog2(NUM_REGS) is a localparam
- NUM_RD_PORTS, 2, combinational read ports
- NUM_WR_PORTS, 1, synchronous write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and reserves
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  NUM_WR_PORTS  per-port write enable
- wr_reg  input  NUM_WR_PORTS*ADDR_W  packed write addresses, port i at [i*ADDR_W +: ADDR_W]
- wr_data  input  NUM_WR_PORTS*DATA_WIDTH  packed write data
- rd_reg  input  NUM_RD_PORTS*ADDR_W  packed read addresses
- rd_data  output  NUM_RD_PORTS*DATA_WIDTH  packed read data
- rd_pending  output  NUM_RD_PORTS  read register has an outstanding reservation
- rsv_en  input  1  mark rsv_reg pending
- rsv_reg  input  ADDR_W  register being reserved
- pending_count  output  ADDR_W+1  registered count of pending registers

## Operation
- Reset (rst=1 at edge): all registers 0, all pending bits 0, pending_count 0. rst overrides any write/reserve in the same cycle.
- Write: at edge, each port with wr_en=1 and valid address stores wr_data. Multiple ports to same address in one cycle: highest-indexed port wins.
- Read: rd_data combinational from array. With BYPASS=1, if any enabled write port targets the read address this cycle, rd_data returns that port's wr_data (highest-indexed hit wins). With BYPASS=0, old value returned.
- ZERO_REG=1: address 0 always reads 0, rd_pending 0; writes and reserves to 0 ignored (no bypass either).
- Invalid address (≥NUM_REGS, non-power-of-2 depth): writes/reserves ignored, reads return 0, rd_pending 0.
- Pending bit: set at edge by rsv_en on rsv_reg; cleared at edge by any write to that register. Reserve and write to same register in same cycle: data updated, pending stays set (new reservation supersedes).
- rd_pending = pending[addr] AND NOT (BYPASS and a write hits addr this cycle). Same-cycle reserve does not affect rd_pending until next cycle.
- pending_count: register equal to popcount of pending bits after each edge; updated incrementally (+1 on new set, -1 per cleared bit, net combined) and must never exceed NUM_REGS. Reserving an already-pending register does not increment.

## Timing
- Read latency 0 (combinational); write/reserve visible to reads the cycle after the edge (same cycle via bypass when BYPASS=1).
- pending_count reflects state after the most recent edge; 1-cycle behind the reserve/write that changed it.
- All outputs defined from the first cycle after reset: rd_data 0, rd_pending 0, pending_count 0.
- No handshakes; caller guarantees one reserve per cycle.

## Test plan
- Reset then read all addresses on both ports -> rd_data 0, rd_pending 0, pending_count 0; write x5=0xDEADBEEF, next cycle rd_reg_1=5 -> 0xDEADBEEF.
- Write x0=0x1234, reserve x0 -> rd_data 0, rd_pending 0, pending_count stays 0.
- BYPASS=1: write x7=0xA5A5A5A5 while rd_reg=7 same cycle -> rd_data 0xA5A5A5A5; BYPASS=0 same stimulus -> previous value, new value next cycle.
- NUM_WR_PORTS=2: both ports write x3 (0x11, 0x22) same cycle -> x3=0x22; reads of x3 that cycle with bypass -> 0x22.
- Reserve x4, x9 on consecutive cycles -> pending_count 1 then 2, rd_pending(4)=1; write x4 -> same-cycle rd_pending(4)=0 (bypass), count 1 next cycle; reserve+write x9 same cycle -> x9 updated, pending stays 1, count 1.
- Assert rst mid-sequence with wr_en=1 and rsv_en=1 -> next cycle all registers 0, pending_count 0, write and reserve discarded.
